// File: rtl/bcd_disp_pkg.sv
// Shared constants for seven-segment display paths: active-low segment codes and a width helper.
// Latency: n/a (package only).
// Backpressure: n/a.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment (common-anode display).
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Counter width for n states; never below 1 bit so n=1 still yields a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: bcd [3:0] digit code in; seg_n [6:0] {g,f,e,d,c,b,a} active-low out.
// Codes 10..15 decode to an all-dark pattern; no error is flagged.
module bcd_to_seven_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode seven-segment scanner with double-buffered BCD digit updates.
// Latency: seg_n/an_n follow the scan index by 1 cycle; loaded digits appear from slot 0 of the next frame.
// Backpressure: none; load is a fire-and-forget strobe, the last load in a frame wins.
// Ports: Clk, Reset_n (async, active-low); load + bcd_in [4*NUM_DIGITS-1:0] ([3:0] = digit 0);
//        seg_n [6:0] active-low segments; an_n [NUM_DIGITS-1:0] one-hot active-low digit enable;
//        frame_done 1-cycle pulse after each complete scan frame.
// Optional build macro LEADING_ZERO_BLANK_EN: darkens leading zero digits (digit 0 always shown).
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 11,
    parameter int PRESCALE   = 50000
)
(
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int CW = idx_width(PRESCALE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] PS_MAX   = CW'(PRESCALE - 1);

    logic [CW-1:0]           ps_cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    pend_flag;
    logic [NUM_DIGITS-1:0]   blank_mask;

    logic                    tick;
    logic                    boundary;
    logic                    disp_wr;
    logic [4*NUM_DIGITS-1:0] disp_next;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              dec_seg;

    assign tick     = (ps_cnt == PS_MAX);
    assign boundary = tick && (idx == LAST_IDX);

    // A load landing on the boundary bypasses the pending buffer and takes priority over it.
    assign disp_wr   = boundary && (load || pend_flag);
    assign disp_next = load ? bcd_in : pend_reg;

    // Select the digit, blank bit and anode for the current slot.
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        an_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit  = disp_reg[4*i +: 4];
                cur_blank  = blank_mask[i];
                an_next[i] = 1'b0;
            end
        end
    end

    bcd_to_seven_seg u_dec (
        .bcd   (cur_digit),
        .seg_n (dec_seg)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ps_cnt     <= '0;
            idx        <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_flag  <= 1'b0;
            seg_n      <= SEG_BLANK;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + CW'(1);
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            end
            frame_done <= boundary;
            seg_n      <= cur_blank ? SEG_BLANK : dec_seg;
            an_n       <= an_next;

            if (disp_wr) begin
                disp_reg <= disp_next;
            end

            if (boundary) begin
                pend_flag <= 1'b0;
            end else if (load) begin
                pend_reg  <= bcd_in;
                pend_flag <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i (i>0) is dark when it and every higher digit are zero; digit 0 never darkens.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  hz;
        m  = '0;
        hz = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            hz   = hz && (d[4*i +: 4] == 4'd0);
            m[i] = hz;
        end
        return m;
    endfunction

    // Reset value matches an all-zero display register.
    localparam logic [NUM_DIGITS-1:0] RST_MASK = ~NUM_DIGITS'(1);

    // Mask is computed once on each display write so the scan path only indexes it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank_mask <= RST_MASK;
        end else if (disp_wr) begin
            blank_mask <= lz_mask(disp_next);
        end
    end
`else
    assign blank_mask = '0;
`endif

endmodule
